pipe_ctrl_chain: RTL and testbench

- Parametrised, valid-tagged pipeline register chain of STAGES entries, WIDTH bits each.
- Generalises the per-signal fixed pipeline registers of the 5-stage core. Adds:
  - valid bits per stage
  - valid/ready handshake at both ends
  - per-stage stall with bubble insertion
  - per-stage flush of younger stages
  - occupancy output
  - saturating stall/flush performance counters
- Stage 0 is the youngest (entry); stage STAGES-1 is the oldest (exit).

---
 rtl/pipe_ctrl_chain.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl_chain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_chain.sv
// Valid-tagged pipeline register chain with valid/ready handshake at both
// ends, per-stage stall (bubble insertion) and flush (kills younger stages),
// occupancy output and saturating stall/flush event counters.
// Stage 0 is the entry (youngest), stage STAGES-1 the exit (oldest).
module pipe_ctrl_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    input  logic [STAGES-1:0]  stall_vec,
    input  logic [STAGES-1:0]  flush_vec,
    input  logic               clr_cnt,
    output logic [OCC_W-1:0]   occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    // Per-cycle flush increment is at most STAGES+1.
    localparam int INC_W = $clog2(STAGES + 2);
    localparam int SUM_W = CNT_W + INC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0] v_q, v_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] acc;
    logic [STAGES-2:0] mv;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [INC_W-1:0]  flush_inc;
    logic [SUM_W-1:0]  flush_sum;

    // Kill mask and ready chain, resolved from the exit stage back to entry.
    // A stalled stage neither accepts nor forwards, so its successor sees a bubble.
    always_comb begin
        logic k_run;
        logic up_acc;
        logic mv_i;
        kill = '0;
        acc  = '0;
        mv   = '0;
        k_run  = flush_vec[STAGES-1];
        kill[STAGES-1] = k_run;
        up_acc = ~stall_vec[STAGES-1] &
                 (~v_q[STAGES-1] | (v_q[STAGES-1] & out_ready));
        acc[STAGES-1] = up_acc;
        for (int i = STAGES - 2; i >= 0; i--) begin
            k_run   = k_run | flush_vec[i];
            kill[i] = k_run;
            mv_i    = v_q[i] & ~stall_vec[i] & up_acc;
            mv[i]   = mv_i;
            up_acc  = ~stall_vec[i] & (~v_q[i] | mv_i);
            acc[i]  = up_acc;
        end
    end

    // Next valid/data per stage: flush beats stall beats transfer.
    always_comb begin
        logic src;
        v_d = v_q;
        for (int i = 0; i < STAGES; i++) data_d[i] = data_q[i];
        if (kill[0]) begin
            v_d[0] = 1'b0;
        end else if (acc[0]) begin
            v_d[0] = in_valid;
            if (in_valid) data_d[0] = in_data;
        end
        for (int i = 1; i < STAGES; i++) begin
            src = mv[i-1] & ~kill[i-1];
            if (kill[i]) begin
                v_d[i] = 1'b0;
            end else if (acc[i]) begin
                v_d[i] = src;
                if (src) data_d[i] = data_q[i-1];
            end
        end
    end

    // Occupancy and saturating counters; clear wins over increment.
    always_comb begin
        occ_d     = '0;
        flush_inc = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d     = occ_d + OCC_W'(v_d[i]);
            flush_inc = flush_inc + INC_W'(v_q[i] & kill[i]);
        end
        flush_inc = flush_inc + INC_W'(in_valid & acc[0] & kill[0]);
        flush_sum = SUM_W'(flush_cnt_q) + SUM_W'(flush_inc);

        stall_cnt_d = stall_cnt_q;
        if (clr_cnt)
            stall_cnt_d = '0;
        else if (in_valid && !acc[0] && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        if (clr_cnt)
            flush_cnt_d = '0;
        else if (flush_sum > SUM_W'(CNT_MAX))
            flush_cnt_d = CNT_MAX;
        else
            flush_cnt_d = flush_sum[CNT_W-1:0];
    end

    // State registers, emptied immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q         <= '0;
            occ_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else begin
            v_q         <= v_d;
            occ_q       <= occ_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
        end
    end

    assign in_ready  = acc[0];
    assign out_valid = v_q[STAGES-1] & ~stall_vec[STAGES-1] & ~kill[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign occupancy = occ_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: table of per-cycle vectors for
// streaming/backpressure plus hand-written stall, flush, saturation and
// async-reset sequences. A second instance with 2-bit counters covers saturation.
module tb_pipe_ctrl_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic [3:0]  stall_vec = '0;
    logic [3:0]  flush_vec = '0;
    logic        clr_cnt = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [2:0]  occupancy;
    logic [15:0] stall_cnt, flush_cnt;

    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;
    logic [2:0]  occupancy2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    always #5 clk = ~clk;

    pipe_ctrl_chain #(.WIDTH(32), .STAGES(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .stall_vec(stall_vec), .flush_vec(flush_vec),
        .clr_cnt(clr_cnt), .occupancy(occupancy), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    pipe_ctrl_chain #(.WIDTH(32), .STAGES(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready), .stall_vec(stall_vec), .flush_vec(flush_vec),
        .clr_cnt(clr_cnt), .occupancy(occupancy2), .stall_cnt(stall_cnt2),
        .flush_cnt(flush_cnt2)
    );

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [31:0] e_od;
        logic [2:0]  e_occ;
        logic [15:0] e_scnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input int iv, input int id, input int ordy,
                                input int irdy, input int ov, input int od,
                                input int occ, input int scnt);
        vec_t r;
        r.iv     = iv[0];
        r.id     = id;
        r.ordy   = ordy[0];
        r.e_irdy = irdy[0];
        r.e_ov   = ov[0];
        r.e_od   = od;
        r.e_occ  = occ[2:0];
        r.e_scnt = scnt[15:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, settle, leave outputs ready to sample.
    task automatic cyc(input int iv, input int id, input int ordy,
                       input int st, input int fl, input int clr);
        @(negedge clk);
        in_valid  = iv[0];
        in_data   = id;
        out_ready = ordy[0];
        stall_vec = st[3:0];
        flush_vec = fl[3:0];
        clr_cnt   = clr[0];
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stall_vec = '0; flush_vec = '0; clr_cnt = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Streaming 1..8 then drain                iv id  ordy irdy ov od occ scnt
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3, 1, 1, 0, 0, 2, 0));
        tbl.push_back(mk(1, 4, 1, 1, 0, 0, 3, 0));
        tbl.push_back(mk(1, 5, 1, 1, 1, 1, 4, 0));
        tbl.push_back(mk(1, 6, 1, 1, 1, 2, 4, 0));
        tbl.push_back(mk(1, 7, 1, 1, 1, 3, 4, 0));
        tbl.push_back(mk(1, 8, 1, 1, 1, 4, 4, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 5, 4, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 6, 3, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 7, 2, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8, 0, 0));
        // Fill A0..A3, hold 5 cycles with out_ready=0, release
        tbl.push_back(mk(1, 'hA0, 1, 1, 0, 8, 0, 0));
        tbl.push_back(mk(1, 'hA1, 1, 1, 0, 8, 1, 0));
        tbl.push_back(mk(1, 'hA2, 1, 1, 0, 8, 2, 0));
        tbl.push_back(mk(1, 'hA3, 1, 1, 0, 8, 3, 0));
        tbl.push_back(mk(1, 'hA4, 0, 0, 1, 'hA0, 4, 0));
        tbl.push_back(mk(1, 'hA4, 0, 0, 1, 'hA0, 4, 1));
        tbl.push_back(mk(1, 'hA4, 0, 0, 1, 'hA0, 4, 2));
        tbl.push_back(mk(1, 'hA4, 0, 0, 1, 'hA0, 4, 3));
        tbl.push_back(mk(1, 'hA4, 0, 0, 1, 'hA0, 4, 4));
        tbl.push_back(mk(1, 'hA4, 1, 1, 1, 'hA0, 4, 5));
        tbl.push_back(mk(1, 'hA5, 1, 1, 1, 'hA1, 4, 5));
        tbl.push_back(mk(0, 0, 1, 1, 1, 'hA2, 4, 5));
        tbl.push_back(mk(0, 0, 1, 1, 1, 'hA3, 3, 5));
        tbl.push_back(mk(0, 0, 1, 1, 1, 'hA4, 2, 5));
        tbl.push_back(mk(0, 0, 1, 1, 1, 'hA5, 1, 5));
        tbl.push_back(mk(0, 0, 1, 1, 0, 'hA5, 0, 5));

        // Reset state
        do_reset();
        #1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst out_data",  out_data, 0);
        check("rst occupancy", 32'(occupancy), 0);
        check("rst in_ready",  32'(in_ready), 1);
        check("rst stall_cnt", 32'(stall_cnt), 0);
        check("rst flush_cnt", 32'(flush_cnt), 0);

        foreach (tbl[r]) begin
            cyc(32'(tbl[r].iv), tbl[r].id, 32'(tbl[r].ordy), 0, 0, 0);
            check($sformatf("row%0d in_ready", r),  32'(in_ready),  32'(tbl[r].e_irdy));
            check($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(tbl[r].e_ov));
            check($sformatf("row%0d out_data", r),  out_data,       tbl[r].e_od);
            check($sformatf("row%0d occupancy", r), 32'(occupancy), 32'(tbl[r].e_occ));
            check($sformatf("row%0d stall_cnt", r), 32'(stall_cnt), 32'(tbl[r].e_scnt));
        end

        // Stall stage 1 for one cycle mid-stream: one output gap, no loss.
        begin
            int          idx = 0;
            logic [31:0] got[$];
            int          vcyc[$];
            do_reset();
            for (int c = 0; c < 16; c++) begin
                cyc(32'(idx < 8), idx + 1, 1, (c == 5) ? 2 : 0, 0, 0);
                if (c == 5) check("stall in_ready", 32'(in_ready), 0);
                if (out_valid) begin
                    got.push_back(out_data);
                    vcyc.push_back(c);
                end
                if (in_valid && in_ready) idx++;
            end
            check("stall beats", 32'(got.size()), 8);
            for (int k = 0; k < got.size() && k < 8; k++)
                check($sformatf("stall beat%0d", k), got[k], 32'(k + 1));
            if (vcyc.size() > 0) begin
                check("stall first_out", 32'(vcyc[0]), 4);
                check("stall gaps", 32'(vcyc[vcyc.size()-1] - vcyc[0] + 1 - vcyc.size()), 1);
            end
            check("stall stall_cnt", 32'(stall_cnt), 1);
        end

        // Flush stages 0..2 with a full chain and an incoming beat.
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 'h10 + k, 1, 0, 0, 0);
        cyc(1, 'h14, 1, 0, 'b0100, 0);
        check("flush out_valid", 32'(out_valid), 1);
        check("flush out_data",  out_data, 'h10);
        check("flush in_ready",  32'(in_ready), 1);
        cyc(0, 0, 1, 0, 0, 0);
        check("flush occupancy", 32'(occupancy), 0);
        check("flush out_valid after", 32'(out_valid), 0);
        check("flush flush_cnt", 32'(flush_cnt), 4);
        check("flush flush_cnt sat", 32'(flush_cnt2), 3);

        // Stall stage 2 while flushing stage 0: stage 2 holds, stage 0 cleared.
        for (int k = 0; k < 4; k++) cyc(1, 'h30 + k, 1, 0, 0, 0);
        cyc(0, 0, 1, 'b0100, 'b0001, 0);
        check("sf out_valid", 32'(out_valid), 1);
        check("sf out_data",  out_data, 'h30);
        check("sf in_ready",  32'(in_ready), 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("sf occupancy", 32'(occupancy), 2);
        check("sf flush_cnt", 32'(flush_cnt), 5);
        check("sf bubble",    32'(out_valid), 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("sf out1 valid", 32'(out_valid), 1);
        check("sf out1 data",  out_data, 'h31);
        cyc(0, 0, 1, 0, 0, 0);
        check("sf out2 valid", 32'(out_valid), 1);
        check("sf out2 data",  out_data, 'h32);
        cyc(0, 0, 1, 0, 0, 0);
        check("sf drained", 32'(out_valid), 0);

        // Counter saturation (2-bit instance) and clear overriding increment.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cyc(1, 'h77, 1, 'b0001, 0, 0);
            check($sformatf("sat c%0d stall_cnt", c), 32'(stall_cnt), 32'(c));
            check($sformatf("sat c%0d stall_cnt2", c), 32'(stall_cnt2), 32'((c > 3) ? 3 : c));
        end
        cyc(1, 'h77, 1, 'b0001, 0, 1);
        check("sat stall_cnt 6", 32'(stall_cnt), 6);
        check("sat stall_cnt2 3", 32'(stall_cnt2), 3);
        cyc(1, 'h77, 1, 'b0001, 0, 0);
        check("clr stall_cnt", 32'(stall_cnt), 0);
        check("clr stall_cnt2", 32'(stall_cnt2), 0);

        // Async reset between edges with three valid beats in flight.
        do_reset();
        cyc(1, 'hEE, 1, 'b0001, 0, 0);
        cyc(1, 'hEE, 1, 0, 'b0001, 0);
        for (int k = 0; k < 4; k++) cyc(1, 'h51 + k, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("pre occupancy", 32'(occupancy), 3);
        check("pre out_valid", 32'(out_valid), 1);
        check("pre out_data",  out_data, 'h52);
        check("pre stall_cnt", 32'(stall_cnt), 1);
        check("pre flush_cnt", 32'(flush_cnt), 1);
        #1 reset = 1'b1;
        #1;
        check("arst out_valid", 32'(out_valid), 0);
        check("arst out_data",  out_data, 0);
        check("arst occupancy", 32'(occupancy), 0);
        check("arst stall_cnt", 32'(stall_cnt), 0);
        check("arst flush_cnt", 32'(flush_cnt), 0);
        check("arst2 out_valid", 32'(out_valid2), 0);
        check("arst2 out_data",  out_data2, 0);
        check("arst2 occupancy", 32'(occupancy2), 0);
        check("arst2 counters",  32'({stall_cnt2, flush_cnt2}), 0);
        #1 reset = 1'b0;
        #0;
        check("arst in_ready",  32'(in_ready), 1);
        check("arst2 in_ready", 32'(in_ready2), 1);
        cyc(0, 0, 1, 0, 0, 0);
        check("post out_valid", 32'(out_valid), 0);
        check("post occupancy", 32'(occupancy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
